// File: rtl/mem_check_seq.sv
// mem_check_seq: preloads a data memory, releases a processor from reset, waits for done
// (with optional timeout), then reads back and compares a table of expected words.
module mem_check_seq #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int N_PRE = 4,
    parameter int N_CHK = 4,
    parameter int TW    = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [$clog2(N_PRE+1)-1:0] i_pre_cnt,
    input  logic [$clog2(N_CHK+1)-1:0] i_chk_cnt,
    input  logic [N_PRE*AW-1:0]        i_pre_addr,
    input  logic [N_PRE*DW-1:0]        i_pre_data,
    input  logic [N_CHK*AW-1:0]        i_chk_addr,
    input  logic [N_CHK*DW-1:0]        i_chk_exp,
    input  logic [TW-1:0]              i_tmo_limit,
    output logic                       o_dut_reset,
    input  logic                       i_dut_done,
    output logic                       o_mem_we,
    output logic [AW-1:0]              o_mem_addr,
    output logic [DW-1:0]              o_mem_wdata,
    input  logic [DW-1:0]              i_mem_rdata,
    output logic                       o_busy,
    output logic                       o_pass,
    output logic                       o_fail,
    output logic                       o_timed_out,
    output logic [$clog2(N_CHK):0]     o_fail_idx
);
    localparam int PCW = $clog2(N_PRE + 1);
    localparam int CCW = $clog2(N_CHK + 1);
    localparam int IW  = PCW > CCW ? PCW : CCW;
    localparam int FIW = $clog2(N_CHK) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRELOAD = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RD      = 3'd4;
    localparam logic [2:0] S_CMP     = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]     r_state;
    logic [IW-1:0]  r_idx;
    logic [TW-1:0]  r_tmo;
    logic           r_pass;
    logic           r_fail;
    logic           r_timed_out;
    logic [FIW-1:0] r_fail_idx;

    logic [PCW-1:0] w_pre_n;
    logic [CCW-1:0] w_chk_n;
    logic [IW-1:0]  w_pre_last;
    logic [IW-1:0]  w_chk_last;
    logic [TW-1:0]  w_tmo_nxt;
    logic [AW-1:0]  w_pre_addr;
    logic [DW-1:0]  w_pre_data;
    logic [AW-1:0]  w_chk_addr;
    logic [DW-1:0]  w_chk_exp;
    logic           w_in_chk;

    // Out-of-range counts clamp to the table size.
    assign w_pre_n    = (i_pre_cnt > PCW'(N_PRE)) ? PCW'(N_PRE) : i_pre_cnt;
    assign w_chk_n    = (i_chk_cnt > CCW'(N_CHK)) ? CCW'(N_CHK) : i_chk_cnt;
    assign w_pre_last = IW'(w_pre_n) - IW'(1);
    assign w_chk_last = IW'(w_chk_n) - IW'(1);
    assign w_tmo_nxt  = r_tmo + TW'(1);
    assign w_pre_addr = i_pre_addr[r_idx*AW +: AW];
    assign w_pre_data = i_pre_data[r_idx*DW +: DW];
    assign w_chk_addr = i_chk_addr[r_idx*AW +: AW];
    assign w_chk_exp  = i_chk_exp[r_idx*DW +: DW];
    assign w_in_chk   = (r_state == S_RD) || (r_state == S_CMP);

    assign o_mem_we    = r_state == S_PRELOAD;
    assign o_mem_addr  = o_mem_we ? w_pre_addr : w_in_chk ? w_chk_addr : '0;
    assign o_mem_wdata = o_mem_we ? w_pre_data : '0;
    assign o_dut_reset = (r_state == S_IDLE) || (r_state == S_PRELOAD) || (r_state == S_DONE);
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_pass      = r_pass;
    assign o_fail      = r_fail;
    assign o_timed_out = r_timed_out;
    assign o_fail_idx  = r_fail_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timed_out <= 1'b0;
            r_fail_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_timed_out <= 1'b0;
                        r_fail_idx  <= '0;
                        r_idx       <= '0;
                        r_state     <= (w_pre_n != '0) ? S_PRELOAD : S_RELEASE;
                    end
                end
                S_PRELOAD: begin
                    if (r_idx == w_pre_last)
                        r_state <= S_RELEASE;
                    else
                        r_idx <= r_idx + IW'(1);
                end
                S_RELEASE: begin
                    r_tmo   <= '0;
                    r_idx   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done is checked first so it wins over a simultaneous timeout.
                    if (i_dut_done) begin
                        r_state <= (w_chk_n == '0) ? S_DONE : S_RD;
                        r_pass  <= w_chk_n == '0;
                    end else if (i_tmo_limit != '0 && w_tmo_nxt == i_tmo_limit) begin
                        r_state     <= S_DONE;
                        r_timed_out <= 1'b1;
                        r_fail      <= 1'b1;
                        r_fail_idx  <= FIW'(N_CHK);
                    end else begin
                        r_tmo <= w_tmo_nxt;
                    end
                end
                S_RD: r_state <= S_CMP;
                S_CMP: begin
                    if (i_mem_rdata != w_chk_exp) begin
                        r_state    <= S_DONE;
                        r_fail     <= 1'b1;
                        r_fail_idx <= FIW'(r_idx);
                    end else if (r_idx == w_chk_last) begin
                        r_state <= S_DONE;
                        r_pass  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                        r_state <= S_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_check_seq.sv
// tb_mem_check_seq: directed and randomized runs against a memory + toy processor model,
// with expected outcomes computed from a table-level reference model.
module tb_mem_check_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        done_force = 1'b0;
    logic [2:0]  pre_cnt = '0;
    logic [2:0]  chk_cnt = '0;
    logic [31:0] pre_addr = '0, pre_data = '0, chk_addr = '0, chk_exp = '0;
    logic [15:0] tmo_limit = '0;
    logic        dut_reset, dut_done, mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        busy, pass, fail, timed_out;
    logic [2:0]  fail_idx;

    logic [7:0]  mem [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    int          proc_delay = 0;
    int          proc_cnt = 0;
    logic        proc_hang = 1'b0;
    logic        proc_done = 1'b0;
    logic [7:0]  proc_dst = 8'h00, proc_a = 8'h00, proc_b = 8'h01;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;
    logic        both_seen;
    logic        tr_we [64];
    logic        tr_rst [64];
    logic [7:0]  tr_addr [64];
    logic [7:0]  tr_wdata [64];

    logic [7:0]  pa [4], pd [4], ca [4], ce [4];
    int          np, nc, dly, lim, e_idx;
    logic        hang, e_pass, e_fail;

    assign dut_done = proc_done | done_force;

    mem_check_seq dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_pre_cnt(pre_cnt), .i_chk_cnt(chk_cnt),
        .i_pre_addr(pre_addr), .i_pre_data(pre_data),
        .i_chk_addr(chk_addr), .i_chk_exp(chk_exp),
        .i_tmo_limit(tmo_limit), .o_dut_reset(dut_reset), .i_dut_done(dut_done),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_busy(busy), .o_pass(pass), .o_fail(fail),
        .o_timed_out(timed_out), .o_fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    // Synchronous memory plus a processor that adds two words after proc_delay cycles.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (dut_reset) begin
            proc_cnt  <= 0;
            proc_done <= 1'b0;
        end else if (!proc_done && !proc_hang) begin
            proc_cnt <= proc_cnt + 1;
            if (proc_cnt == proc_delay) begin
                mem[proc_dst] <= mem[proc_a] + mem[proc_b];
                proc_done     <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pre(input int i, input int a, input int d);
        pre_addr[i*8 +: 8] = 8'(a);
        pre_data[i*8 +: 8] = 8'(d);
    endtask

    task automatic set_chk(input int i, input int a, input int d);
        chk_addr[i*8 +: 8] = 8'(a);
        chk_exp[i*8 +: 8]  = 8'(d);
    endtask

    task automatic run(input int budget);
        for (int k = 0; k < 64; k++) begin
            tr_we[k] = 1'b0; tr_rst[k] = 1'b1; tr_addr[k] = '0; tr_wdata[k] = '0;
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        both_seen = 1'b0;
        forever begin
            if (cyc < 64) begin
                tr_we[cyc] = mem_we; tr_rst[cyc] = dut_reset;
                tr_addr[cyc] = mem_addr; tr_wdata[cyc] = mem_wdata;
            end
            if (pass && fail) both_seen = 1'b1;
            if (!busy || cyc >= budget) break;
            @(negedge clk);
            cyc++;
        end
        chk("run_ends", 32'(busy), 0);
        chk("pass_fail_excl", 32'(both_seen), 0);
    endtask

    function automatic int n_low();
        int n = 0;
        for (int k = 1; k < 64 && k <= cyc; k++) if (!tr_rst[k]) n++;
        return n;
    endfunction

    function automatic int n_we();
        int n = 0;
        for (int k = 1; k < 64 && k <= cyc; k++) if (tr_we[k]) n++;
        return n;
    endfunction

    function automatic int n_rd_addr(input logic [7:0] a);
        int n = 0;
        for (int k = 1; k < 64 && k <= cyc; k++) if (!tr_rst[k] && !tr_we[k] && tr_addr[k] == a) n++;
        return n;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dut_reset", 32'(dut_reset), 1);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_flags", 32'({pass, fail, timed_out}), 0);
        chk("rst_fail_idx", 32'(fail_idx), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Two-word preload, processor adds, one passing check.
        pre_cnt = 3'd2; set_pre(0, 1, 3); set_pre(1, 0, 4);
        chk_cnt = 3'd1; set_chk(0, 0, 7);
        tmo_limit = 16'd20; proc_delay = 2;
        run(60);
        chk("add_we_c1", 32'({tr_we[1], tr_addr[1], tr_wdata[1]}), 32'({1'b1, 8'd1, 8'd3}));
        chk("add_we_c2", 32'({tr_we[2], tr_addr[2], tr_wdata[2]}), 32'({1'b1, 8'd0, 8'd4}));
        chk("add_we_c3", 32'(tr_we[3]), 0);
        chk("add_rst_c2", 32'(tr_rst[2]), 1);
        chk("add_rst_c3", 32'(tr_rst[3]), 0);
        chk("add_pass", 32'({pass, fail, timed_out}), 32'(3'b100));
        chk("add_mem0", 32'(mem[0]), 7);

        set_chk(0, 0, 8);
        run(60);
        chk("bad_flags", 32'({pass, fail, timed_out}), 32'(3'b010));
        chk("bad_idx", 32'(fail_idx), 0);

        // Processor never finishes: timeout after exactly 5 WAIT cycles.
        pre_cnt = 3'd1; set_pre(0, 5, 9); proc_hang = 1'b1; tmo_limit = 16'd5;
        run(60);
        chk("tmo_low_cycles", n_low(), 6);
        chk("tmo_flags", 32'({pass, fail, timed_out}), 32'(3'b011));
        chk("tmo_idx", 32'(fail_idx), 4);
        chk("tmo_dut_reset", 32'(dut_reset), 1);

        // Done arriving in the timeout cycle wins; one cycle later it loses.
        proc_hang = 1'b0; pre_cnt = 3'd0; chk_cnt = 3'd0; tmo_limit = 16'd3; proc_delay = 2;
        run(60);
        chk("race_done_wins", 32'({pass, fail, timed_out}), 32'(3'b100));
        proc_delay = 3;
        run(60);
        chk("race_tmo_wins", 32'({pass, fail, timed_out}), 32'(3'b011));

        // Middle entry mismatches; third entry must never be read.
        pre_cnt = 3'd3; set_pre(0, 8'h10, 8'h0A); set_pre(1, 8'h11, 8'h0B); set_pre(2, 8'h55, 8'h0C);
        chk_cnt = 3'd3; set_chk(0, 8'h10, 8'h0A); set_chk(1, 8'h11, 8'hEE); set_chk(2, 8'h55, 8'h0C);
        tmo_limit = 16'd0; proc_delay = 1;
        run(60);
        chk("mid_flags", 32'({pass, fail}), 32'(2'b01));
        chk("mid_idx", 32'(fail_idx), 1);
        chk("mid_no_rd2", n_rd_addr(8'h55), 0);

        // Empty run with done already high.
        pre_cnt = 3'd0; chk_cnt = 3'd0; done_force = 1'b1;
        run(60);
        chk("empty_pass", 32'({pass, fail}), 32'(2'b10));
        chk("empty_fast", 32'(cyc <= 4), 1);
        chk("empty_no_we", n_we(), 0);
        done_force = 1'b0;

        // Counts above the table size clamp to four entries.
        pre_cnt = 3'd7; chk_cnt = 3'd7; proc_dst = 8'h3F; proc_a = 8'h3E; proc_b = 8'h3E;
        for (int i = 0; i < 4; i++) begin
            set_pre(i, 8'h30 + i, 8'h41 + i);
            set_chk(i, 8'h30 + i, 8'h41 + i);
        end
        run(60);
        chk("sat_we", n_we(), 4);
        chk("sat_pass", 32'({pass, fail}), 32'(2'b10));
        chk("sat_mem", 32'(mem[8'h33]), 32'h44);

        // Asynchronous reset in WAIT abandons the run.
        pre_cnt = 3'd0; chk_cnt = 3'd1; set_chk(0, 8'h30, 8'h41); proc_hang = 1'b1; tmo_limit = 16'd0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_pre_wait", 32'({busy, dut_reset}), 32'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'({busy, dut_reset, mem_we}), 32'(3'b010));
        chk("arst_flags", 32'({pass, fail, timed_out, fail_idx}), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_no_resume", 32'({busy, dut_reset}), 32'(2'b01));
        proc_hang = 1'b0; proc_delay = 0;
        run(60);
        chk("arst_rerun", 32'({pass, fail, timed_out}), 32'(3'b100));

        // Randomized runs in region 0x20..0x27 against a table-level model.
        proc_dst = 8'h20; proc_a = 8'h20; proc_b = 8'h21;
        for (int it = 0; it < 20; it++) begin
            pre_cnt = 3'($urandom_range(0, 7));
            chk_cnt = 3'($urandom_range(0, 7));
            np = pre_cnt > 3'd4 ? 4 : int'(pre_cnt);
            nc = chk_cnt > 3'd4 ? 4 : int'(chk_cnt);
            for (int i = 0; i < 4; i++) begin
                pa[i] = 8'h20 + 8'($urandom_range(0, 7));
                pd[i] = 8'($urandom);
                set_pre(i, pa[i], pd[i]);
            end
            for (int i = 0; i < np; i++) ref_mem[pa[i]] = pd[i];
            hang = $urandom_range(0, 3) == 0;
            dly = $urandom_range(0, 5);
            lim = hang ? $urandom_range(1, 8) : ($urandom_range(0, 1) != 0 ? 0 : dly + 1 + $urandom_range(0, 6));
            if (!hang) ref_mem[8'h20] = ref_mem[8'h20] + ref_mem[8'h21];
            for (int i = 0; i < 4; i++) begin
                ca[i] = 8'h20 + 8'($urandom_range(0, 7));
                ce[i] = $urandom_range(0, 2) == 0 ? 8'($urandom) : ref_mem[ca[i]];
                set_chk(i, ca[i], ce[i]);
            end
            e_pass = !hang; e_fail = hang; e_idx = hang ? 4 : 0;
            for (int i = 0; i < nc && !hang; i++) begin
                if (ce[i] != ref_mem[ca[i]]) begin
                    e_pass = 1'b0; e_fail = 1'b1; e_idx = i;
                    break;
                end
            end
            proc_hang = hang; proc_delay = dly; tmo_limit = 16'(lim);
            run(200);
            chk("rnd_flags", 32'({pass, fail, timed_out}), 32'({e_pass, e_fail, hang}));
            chk("rnd_idx", 32'(fail_idx), e_idx);
            if (hang) chk("rnd_tmo_len", n_low(), lim + 1);
            for (int a = 8'h20; a < 8'h28; a++) chk("rnd_mem", 32'(mem[a]), 32'(ref_mem[a]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
